if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 162 ++++++++++++++++
 tb/tb_if_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch front end: issues one fetch at a time on an SRAM-like
// instruction bus and hands returned instructions to decode through a
// ready/valid output stage.
// Build option: define IF_SKID_BUF_EN to add a one-entry skid buffer behind the
// ID registers, so a fetch can be issued while decode is stalled.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no fetch outstanding; request issued when output space exists
// S_WAIT    | address accepted, waiting for inst_data_ok
// S_DISCARD | flushed while waiting; the next inst_data_ok is dropped
module if_fetch (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] IF_PC,
   output logic        IF_PCWr,
   input  logic        flush,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic        ID_valid,
   output logic [31:0] ID_Instr,
   output logic [31:0] ID_PC,
   input  logic        ID_ready
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_inflight;
   logic        space;
   logic        consume;
   logic        deliver;

`ifdef IF_SKID_BUF_EN
   logic        skid_valid;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;
`endif

   assign inst_addr = IF_PC;
   assign consume   = ID_valid && ID_ready;

   // Output space: somewhere for a returning instruction to land.
   always_comb begin
`ifdef IF_SKID_BUF_EN
      space = !ID_valid || ID_ready || !skid_valid;
`else
      space = !ID_valid || ID_ready;
`endif
   end

   // Request FSM next-state and bus/PC outputs.
   always_comb begin
      state_nxt = state;
      inst_req  = 1'b0;
      IF_PCWr   = 1'b0;
      deliver   = 1'b0;
      case (state)
         S_IDLE: begin
            // Reset gating keeps the bus quiet during the reset cycle itself.
            inst_req = resetn && !flush && space;
            if (inst_req && inst_addr_ok) begin
               IF_PCWr   = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (inst_data_ok) begin
               deliver   = !flush;
               state_nxt = S_IDLE;
            end else if (flush) begin
               state_nxt = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (inst_data_ok) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Capture the address of the accepted fetch to tag its returning data.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pc_inflight <= 32'd0;
      end else if (IF_PCWr) begin
         pc_inflight <= IF_PC;
      end
   end

   // Output stage: ID registers (plus optional skid entry), oldest in ID.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ID_valid   <= 1'b0;
         ID_Instr   <= 32'd0;
         ID_PC      <= 32'd0;
`ifdef IF_SKID_BUF_EN
         skid_valid <= 1'b0;
         skid_instr <= 32'd0;
         skid_pc    <= 32'd0;
`endif
      end else if (flush) begin
         ID_valid   <= 1'b0;
`ifdef IF_SKID_BUF_EN
         skid_valid <= 1'b0;
`endif
      end else begin
`ifdef IF_SKID_BUF_EN
         if (consume && skid_valid) begin
            // Skid drains into ID without a bubble; a same-cycle return refills it.
            ID_valid   <= 1'b1;
            ID_Instr   <= skid_instr;
            ID_PC      <= skid_pc;
            skid_valid <= deliver;
            if (deliver) begin
               skid_instr <= inst_rdata;
               skid_pc    <= pc_inflight;
            end
         end else if (deliver && (!ID_valid || consume)) begin
            ID_valid <= 1'b1;
            ID_Instr <= inst_rdata;
            ID_PC    <= pc_inflight;
         end else if (deliver) begin
            skid_valid <= 1'b1;
            skid_instr <= inst_rdata;
            skid_pc    <= pc_inflight;
         end else if (consume) begin
            ID_valid <= 1'b0;
         end
`else
         // A request only issues with space, so a return never meets a stalled ID.
         if (deliver) begin
            ID_valid <= 1'b1;
            ID_Instr <= inst_rdata;
            ID_PC    <= pc_inflight;
         end else if (consume) begin
            ID_valid <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by random traffic, all checked
// against a transaction-level model (queue of instructions awaiting decode plus
// the single outstanding fetch).
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] IF_PC;
   logic        IF_PCWr;
   logic        flush;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        ID_valid;
   logic [31:0] ID_Instr;
   logic [31:0] ID_PC;
   logic        ID_ready;

   always #5 clk = ~clk;

   if_fetch dut (
      .clk          (clk),
      .resetn       (resetn),
      .IF_PC        (IF_PC),
      .IF_PCWr      (IF_PCWr),
      .flush        (flush),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .ID_valid     (ID_valid),
      .ID_Instr     (ID_Instr),
      .ID_PC        (ID_PC),
      .ID_ready     (ID_ready)
   );

`ifdef IF_SKID_BUF_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   ent_t        q[$];
   bit          pend;
   bit          doomed;
   logic [31:0] pend_pc;
   logic [31:0] pc_cur;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          pcwr_seen = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check against the model, advance the model.
   task automatic cyc(input bit rst_n, input bit fl, input bit aok, input bit dok,
                      input bit rdy, input logic [31:0] rdata);
      bit space;
      bit exp_req;
      bit exp_wr;
      bit take;
      bit give;
      resetn       = rst_n;
      flush        = fl;
      inst_addr_ok = aok;
      inst_data_ok = dok;
      ID_ready     = rdy;
      inst_rdata   = rdata;
      IF_PC        = pc_cur;
      #3;
      space   = (q.size() == 0) || rdy || (q.size() < CAP);
      exp_req = rst_n && !pend && !fl && space;
      exp_wr  = exp_req && aok;
      check("inst_req", {31'd0, inst_req}, {31'd0, exp_req});
      check("IF_PCWr", {31'd0, IF_PCWr}, {31'd0, exp_wr});
      check("inst_addr", inst_addr, pc_cur);
      check("ID_valid", {31'd0, ID_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
         check("ID_Instr", ID_Instr, q[0].instr);
         check("ID_PC", ID_PC, q[0].pc);
      end
      if (IF_PCWr) pcwr_seen++;
      if (!rst_n) begin
         q.delete();
         pend   = 1'b0;
         doomed = 1'b0;
      end else begin
         take = (q.size() > 0) && rdy;
         give = pend && dok && !fl && !doomed;
         if (pend && dok) pend = 1'b0;
         if (fl) begin
            q.delete();
            if (pend) doomed = 1'b1;
         end else begin
            if (take) void'(q.pop_front());
            if (give) q.push_back(ent_t'{instr: rdata, pc: pend_pc});
         end
         if (exp_wr) begin
            pend    = 1'b1;
            doomed  = 1'b0;
            pend_pc = pc_cur;
         end
      end
      if (exp_wr) pc_cur = pc_cur + 32'd4;
      if (fl) pc_cur = $urandom() & 32'hFFFF_FFFC;
      @(posedge clk);
      #1;
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      ID_ready = 1'b0; inst_rdata = 32'd0; IF_PC = 32'd0;
      pend = 1'b0; doomed = 1'b0; pend_pc = 32'd0;
      pc_cur = 32'hBFC0_0000;
      @(posedge clk);
      #1;

      // Reset state
      cyc(0, 0, 1, 1, 1, 32'h1111_1111);
      cyc(0, 0, 1, 0, 1, 32'd0);
      check("rst_ID_valid", {31'd0, ID_valid}, 32'd0);
      check("rst_ID_Instr", ID_Instr, 32'd0);
      check("rst_ID_PC", ID_PC, 32'd0);

      // Basic fetch
      cyc(1, 0, 1, 0, 1, 32'd0);
      cyc(1, 0, 0, 1, 1, 32'h2408_0001);
      check("basic_valid", {31'd0, ID_valid}, 32'd1);
      check("basic_instr", ID_Instr, 32'h2408_0001);
      check("basic_pc", ID_PC, 32'hBFC0_0000);

      // Stall for five cycles (skid build: one more fetch lands in the skid)
      cyc(1, 0, 1, 0, 0, 32'h2409_0002);
      cyc(1, 0, 1, 1, 0, 32'h2409_0002);
      cyc(1, 0, 1, 1, 0, 32'h2409_0002);
      cyc(1, 0, 1, 1, 0, 32'h2409_0002);
      cyc(1, 0, 1, 1, 0, 32'h2409_0002);
      check("stall_instr", ID_Instr, 32'h2408_0001);
      check("stall_pc", ID_PC, 32'hBFC0_0000);
      cyc(1, 0, 0, 0, 1, 32'd0);
      cyc(1, 0, 0, 0, 1, 32'd0);
      cyc(1, 0, 0, 0, 1, 32'd0);

      // Flush while waiting; the late response must be dropped
      pc_cur = 32'hBFC0_0008;
      cyc(1, 0, 1, 0, 1, 32'd0);
      cyc(1, 1, 0, 0, 1, 32'd0);
      cyc(1, 0, 0, 1, 1, 32'hDEAD_BEEF);
      check("flushw_valid", {31'd0, ID_valid}, 32'd0);
      cyc(1, 0, 0, 0, 1, 32'd0);

      // Flush coincident with data_ok
      cyc(1, 0, 1, 0, 1, 32'd0);
      cyc(1, 1, 1, 1, 1, 32'hCAFE_F00D);
      check("flushd_valid", {31'd0, ID_valid}, 32'd0);

      // addr_ok held off for three cycles
      pcwr_seen = 0;
      cyc(1, 0, 0, 0, 1, 32'd0);
      cyc(1, 0, 0, 0, 1, 32'd0);
      cyc(1, 0, 0, 0, 1, 32'd0);
      cyc(1, 0, 1, 0, 1, 32'd0);
      cyc(1, 0, 0, 1, 1, 32'h0000_0123);
      cyc(1, 0, 0, 0, 1, 32'd0);
      check("delay_pcwr_count", pcwr_seen, 32'd1);

      // Reset in the middle of a fetch, then a clean fetch
      cyc(1, 0, 1, 0, 1, 32'd0);
      cyc(0, 0, 0, 0, 1, 32'd0);
      check("rstw_valid", {31'd0, ID_valid}, 32'd0);
      check("rstw_instr", ID_Instr, 32'd0);
      check("rstw_pc", ID_PC, 32'd0);
      pc_cur = 32'hBFC0_0100;
      cyc(1, 0, 1, 0, 1, 32'd0);
      cyc(1, 0, 0, 1, 1, 32'h3C1D_A000);
      check("rstw_fetch_instr", ID_Instr, 32'h3C1D_A000);
      check("rstw_fetch_pc", ID_PC, 32'hBFC0_0100);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(99) != 0,
             $urandom_range(19) == 0,
             $urandom_range(1) == 1,
             $urandom_range(9) < 4,
             $urandom_range(9) < 6,
             $urandom());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
